// File: rtl/cla8_mp_add_seq_if.sv
// Operand/result handshake bundle for the multi-precision adder sequencer.
// The sequencer takes the slave side; the operand producer and result consumer take the master side.
interface cla8_mp_add_seq_if #(
    parameter int unsigned NBYTES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   op_a;
    logic [8*NBYTES-1:0]   op_b;
    logic                  op_cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   sum;
    logic                  cout;
    logic                  ovf;

    modport master (
        output in_valid, op_a, op_b, op_cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, op_a, op_b, op_cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla8_mp_add_seq.sv
// Multi-precision adder: one 8-bit carry-lookahead adder time-shared over NBYTES bytes,
// least-significant byte first, with the carry chained through a register.

module cla8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       term;

    // Each carry is a flat sum of generate terms propagated forward, plus cin through all p.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        term = 1'b0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        sum  = p ^ c[7:0];
        cout = c[8];
    end
endmodule

module cla8_mp_add_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cla8_mp_add_seq_if.slave        bus
);
    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic            cout_q;
    logic            ovf_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      cla_sum;
    logic            cla_cout;

    assign a_byte = a_q[8*idx_q +: 8];
    assign b_byte = b_q[8*idx_q +: 8];

    cla8 u_cla8 (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.op_a;
                        b_q        <= bus.op_b;
                        carry_q    <= bus.op_cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    sum_q[8*idx_q +: 8] <= cla_sum;
                    carry_q             <= cla_cout;
                    if (idx_q == LAST) begin
                        cout_q      <= cla_cout;
                        // Overflow uses the MSB of the byte being written this cycle.
                        ovf_q       <= (a_q[W-1] == b_q[W-1]) && (cla_sum[7] != a_q[W-1]);
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla8_mp_add_seq.sv
// Scoreboard bench for cla8_mp_add_seq: accepted operands push a plain-arithmetic expectation,
// a monitor pops and compares whenever a result is presented.
module tb_cla8_mp_add_seq;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   cyc;
    exp_t exp_q[$];
    exp_t cur;
    logic have;
    logic hs_pending;

    cla8_mp_add_seq_if #(.NBYTES(NBYTES)) bus ();

    cla8_mp_add_seq #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: full-width integer addition, overflow from operand and result signs.
    always @(posedge clk) begin
        exp_t e;
        logic [W:0] full;
        cyc = cyc + 1;
        hs_pending = rst_n && bus.out_valid && bus.out_ready;
        if (hs_pending) have = 1'b0;
        if (rst_n && bus.in_valid && bus.in_ready) begin
            full   = {1'b0, bus.op_a} + {1'b0, bus.op_b} + {{W{1'b0}}, bus.op_cin};
            e.sum  = full[W-1:0];
            e.cout = full[W];
            e.ovf  = (bus.op_a[W-1] == bus.op_b[W-1]) && (full[W-1] != bus.op_a[W-1]);
            e.acc  = cyc;
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            have       = 1'b0;
            hs_pending = 1'b0;
        end else begin
            if (hs_pending) begin
                chk("post_hs_out_valid", {63'd0, bus.out_valid}, 64'd0);
                chk("post_hs_in_ready", {63'd0, bus.in_ready}, 64'd1);
                hs_pending = 1'b0;
            end
            if (bus.out_valid) begin
                if (!have) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        cur  = exp_q.pop_front();
                        have = 1'b1;
                        chk("latency", 64'(cyc - cur.acc), 64'(NBYTES));
                        chk("sum", 64'(bus.sum), 64'(cur.sum));
                        chk("cout", {63'd0, bus.cout}, {63'd0, cur.cout});
                        chk("ovf", {63'd0, bus.ovf}, {63'd0, cur.ovf});
                    end
                end else begin
                    chk("hold_sum", 64'(bus.sum), 64'(cur.sum));
                    chk("hold_cout", {63'd0, bus.cout}, {63'd0, cur.cout});
                    chk("hold_ovf", {63'd0, bus.ovf}, {63'd0, cur.ovf});
                    chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
                end
            end
        end
    end

    task automatic wait_in_ready();
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int bp);
        int n;
        bus.out_ready = (bp == 0);
        wait_in_ready();
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_cin   = cin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        bus.op_cin   = 1'($urandom);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.out_valid) chk("result_timeout", 64'd1, 64'd0);
        for (int i = 0; i < bp; i++) begin
            // A stray request during backpressure must not be taken.
            bus.in_valid = (i == 1);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        chk({tag, "_sum"}, 64'(bus.sum), 64'd0);
        chk({tag, "_cout"}, {63'd0, bus.cout}, 64'd0);
        chk({tag, "_ovf"}, {63'd0, bus.ovf}, 64'd0);
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        cyc           = 0;
        have          = 1'b0;
        hs_pending    = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_cin    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(32'h0000000F, 32'h00000001, 1'b0, 0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
        run_op(32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 0);
        run_op(32'h80000000, 32'h80000000, 1'b0, 5);

        // Abort an operation two bytes in; nothing from it may ever be presented.
        wait_in_ready();
        bus.op_a     = 32'h12345678;
        bus.op_b     = 32'h9ABCDEF0;
        bus.op_cin   = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_values("midrun_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrun_no_output", {63'd0, bus.out_valid}, 64'd0);

        run_op(32'hAAAAAAAA, 32'h55555555, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
